// File: rtl/rf_fwd_if.sv
// rf_fwd port bundle: register-read, forwarding and write signals.
// master drives reads/writes, slave is the register file.
interface rf_fwd_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NFWD = 3
);
  logic [NRD*AW-1:0]          raddr;
  logic [NRD-1:0]             rd_en;
  logic [NRD*DW-1:0]          rdata;
  logic [NFWD*(DW+AW+2)-1:0]  fwd_bus;
  logic                       we;
  logic [AW-1:0]              waddr;
  logic [DW-1:0]              wdata;
  logic                       stall_o;
  logic                       init_busy;

  modport master (
    output raddr, rd_en, fwd_bus,
    output we, waddr, wdata,
    input  rdata, stall_o, init_busy
  );

  modport slave (
    input  raddr, rd_en, fwd_bus,
    input  we, waddr, wdata,
    output rdata, stall_o, init_busy
  );
endinterface

// File: rtl/rf_fwd.sv
// rf_fwd: register file with self-clearing init and stage forwarding.
// Optional HI/LO pair enabled by defining RF_HILO_EN.
module rf_fwd #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NFWD = 3
) (
  input  logic clk,
  input  logic resetn,
  rf_fwd_if.slave bus
`ifdef RF_HILO_EN
  ,
  input  logic [NFWD*(2*DW+2)-1:0] hilo_fwd_bus,
  input  logic                     hi_we,
  input  logic                     lo_we,
  input  logic [DW-1:0]            hi_i,
  input  logic [DW-1:0]            lo_i,
  output logic [DW-1:0]            hi_o,
  output logic [DW-1:0]            lo_o
`endif
);

  localparam int FW    = DW + AW + 2;
  localparam int DEPTH = 2**AW;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init;

  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] f_dt [NFWD];
  logic [AW-1:0] f_wa [NFWD];
  logic          f_we [NFWD];
  logic          f_rd [NFWD];

  logic [DW-1:0] rd_v [NRD];
  logic [NRD-1:0] hz;

  assign init = (state_q == INIT);

  // state and clear-counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: sweep every entry once, then run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == INIT): begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // storage: clear during INIT, architectural writes in RUN
  always_ff @(posedge clk) begin
    if (init) begin
      mem[cnt_q] <= '0;
    end else if (bus.we && bus.waddr != '0) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // unpack forwarding stages
  always_comb begin
    for (int s = 0; s < NFWD; s++) begin
      f_dt[s] = bus.fwd_bus[s*FW +: DW];
      f_wa[s] = bus.fwd_bus[s*FW+DW +: AW];
      f_we[s] = bus.fwd_bus[s*FW+DW+AW];
      f_rd[s] = bus.fwd_bus[s*FW+DW+AW+1];
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = bus.raddr[g*AW +: AW];

    // read mux: older sources first so younger ones override
    always_comb begin
      rd_v[g] = mem[ra];
      hz[g]   = 1'b0;
      if (bus.we && bus.waddr == ra) begin
        rd_v[g] = bus.wdata;
      end
      for (int s = NFWD-1; s >= 0; s--) begin
        if (f_we[s] && f_wa[s] == ra) begin
          rd_v[g] = f_rd[s] ? f_dt[s] : '0;
          hz[g]   = !f_rd[s];
        end
      end
      if (init || ra == '0) begin
        rd_v[g] = '0;
        hz[g]   = 1'b0;
      end
    end
  end

  // pack read data onto the bus
  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      bus.rdata[i*DW +: DW] = rd_v[i];
    end
  end

  assign bus.stall_o   = init | (|(bus.rd_en & hz));
  assign bus.init_busy = init;

`ifdef RF_HILO_EN
  localparam int HW = 2*DW + 2;

  logic [DW-1:0] hi_q, lo_q;

  // HI/LO registers, written only in RUN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!init) begin
      if (hi_we) hi_q <= hi_i;
      if (lo_we) lo_q <= lo_i;
    end
  end

  // HI/LO read: stage beats bypass beats register
  always_comb begin
    hi_o = hi_we ? hi_i : hi_q;
    lo_o = lo_we ? lo_i : lo_q;
    for (int s = NFWD-1; s >= 0; s--) begin
      if (hilo_fwd_bus[s*HW+2*DW+1]) hi_o = hilo_fwd_bus[s*HW+DW +: DW];
      if (hilo_fwd_bus[s*HW+2*DW])   lo_o = hilo_fwd_bus[s*HW +: DW];
    end
    if (init) begin
      hi_o = '0;
      lo_o = '0;
    end
  end
`endif

endmodule

// File: tb/tb_rf_fwd.sv
// Scoreboard bench for rf_fwd: directed vectors push expectations,
// a monitor pops and compares them against the live outputs.
`timescale 1ns/1ps
module tb_rf_fwd;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NFWD = 3;
  localparam int FW   = DW + AW + 2;
  localparam int HW   = 2*DW + 2;

  localparam int K_RD0  = 0;
  localparam int K_RD1  = 1;
  localparam int K_STL  = 2;
  localparam int K_BSY  = 3;
  localparam int K_HI   = 4;
  localparam int K_LO   = 5;
  localparam int K_VAL  = 6;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
    logic [31:0] act;
  } item_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  item_t q[$];
  event  ev;

  rf_fwd_if #(.DW(DW), .AW(AW), .NRD(NRD), .NFWD(NFWD)) bus ();

`ifdef RF_HILO_EN
  logic [NFWD*HW-1:0] hilo_fwd_bus;
  logic               hi_we, lo_we;
  logic [DW-1:0]      hi_i, lo_i, hi_o, lo_o;
`endif

  rf_fwd #(.DW(DW), .AW(AW), .NRD(NRD), .NFWD(NFWD)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus.slave)
`ifdef RF_HILO_EN
    ,
    .hilo_fwd_bus(hilo_fwd_bus),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .hi_i(hi_i),
    .lo_i(lo_i),
    .hi_o(hi_o),
    .lo_o(lo_o)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FW-1:0] stg(
    input logic rdy, input logic w,
    input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {rdy, w, a, d};
  endfunction

  task automatic set_stage(input int s, input logic [FW-1:0] v);
    bus.fwd_bus[s*FW +: FW] = v;
  endtask

  task automatic idle();
    bus.raddr   = '0;
    bus.rd_en   = '0;
    bus.fwd_bus = '0;
    bus.we      = 1'b0;
    bus.waddr   = '0;
    bus.wdata   = '0;
`ifdef RF_HILO_EN
    hilo_fwd_bus = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_i  = '0;
    lo_i  = '0;
`endif
  endtask

  task automatic ex(input string n, input int k,
                    input logic [31:0] e,
                    input logic [31:0] a = 32'h0);
    item_t it;
    it.name = n;
    it.kind = k;
    it.exp  = e;
    it.act  = a;
    q.push_back(it);
  endtask

  task automatic chk(input string n,
                     input logic [31:0] e,
                     input logic [31:0] a);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic fire();
    #1;
    ->ev;
    #1;
  endtask

  task automatic count_init(input string n);
    int c;
    c = 0;
    while (bus.init_busy && c < 200) begin
      c++;
      @(negedge clk);
    end
    chk({n, "_timeout"}, 32'd0, {31'h0, c >= 200});
    chk(n, 32'd32, c);
  endtask

  // monitor: drain the scoreboard against current DUT outputs
  initial begin
    item_t it;
    logic [31:0] act;
    forever begin
      @(ev);
      while (q.size() > 0) begin
        it = q.pop_front();
        case (it.kind)
          K_RD0: act = bus.rdata[0 +: DW];
          K_RD1: act = bus.rdata[DW +: DW];
          K_STL: act = {31'h0, bus.stall_o};
          K_BSY: act = {31'h0, bus.init_busy};
`ifdef RF_HILO_EN
          K_HI:  act = hi_o;
          K_LO:  act = lo_o;
`endif
          default: act = it.act;
        endcase
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h",
                   it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    idle();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    bus.raddr = {5'd0, 5'd3};
    bus.we    = 1'b1;
    bus.waddr = 5'd3;
    bus.wdata = 32'hDEAD;
    ex("rst_busy", K_BSY, 32'd1);
    ex("rst_stall", K_STL, 32'd1);
    ex("rst_rd0", K_RD0, 32'd0);
    fire();
    chk("rst_busy_d", 32'd1, {31'h0, bus.init_busy});
    chk("rst_stall_d", 32'd1, {31'h0, bus.stall_o});
    chk("rst_rd0_d", 32'd0, bus.rdata[0 +: DW]);
    count_init("init_len");

    idle();
    ex("run_busy", K_BSY, 32'd0);
    ex("run_stall", K_STL, 32'd0);
    fire();
    for (int a = 0; a < 32; a++) begin
      bus.raddr = {5'(31 - a), 5'(a)};
      bus.rd_en = 2'b11;
      ex($sformatf("clr0_r%0d", a), K_RD0, 32'd0);
      ex($sformatf("clr1_r%0d", 31 - a), K_RD1, 32'd0);
      fire();
      @(negedge clk);
    end

    idle();
    bus.raddr = {5'd3, 5'd3};
    bus.rd_en = 2'b01;
    set_stage(0, stg(1'b1, 1'b1, 5'd3, 32'hAAAA));
    set_stage(2, stg(1'b1, 1'b1, 5'd3, 32'hBBBB));
    bus.we    = 1'b1;
    bus.waddr = 5'd3;
    bus.wdata = 32'hCCCC;
    ex("pri_s0", K_RD0, 32'hAAAA);
    ex("pri_same", K_RD1, 32'hAAAA);
    ex("pri_nostall", K_STL, 32'd0);
    fire();
    set_stage(0, '0);
    ex("pri_s2", K_RD0, 32'hBBBB);
    fire();
    set_stage(2, '0);
    ex("pri_wt", K_RD0, 32'hCCCC);
    fire();
    @(negedge clk);
    idle();
    bus.raddr = {5'd0, 5'd3};
    ex("stored_r3", K_RD0, 32'hCCCC);
    fire();

    idle();
    bus.raddr = {5'd7, 5'd3};
    bus.rd_en = 2'b10;
    set_stage(0, stg(1'b0, 1'b1, 5'd7, 32'h5555));
    ex("lu_stall", K_STL, 32'd1);
    ex("lu_rd1", K_RD1, 32'd0);
    ex("lu_other", K_RD0, 32'hCCCC);
    fire();
    bus.rd_en = 2'b00;
    ex("lu_unused", K_STL, 32'd0);
    fire();
    @(negedge clk);

    idle();
    bus.we    = 1'b1;
    bus.waddr = 5'd0;
    bus.wdata = 32'hFFFFFFFF;
    set_stage(1, stg(1'b1, 1'b1, 5'd0, 32'h9999));
    ex("r0_same0", K_RD0, 32'd0);
    ex("r0_same1", K_RD1, 32'd0);
    fire();
    @(negedge clk);
    idle();
    bus.raddr = {5'd0, 5'd0};
    ex("r0_next0", K_RD0, 32'd0);
    ex("r0_next1", K_RD1, 32'd0);
    fire();

`ifdef RF_HILO_EN
    idle();
    hilo_fwd_bus[1*HW +: HW] = {1'b1, 1'b0, 32'h11, 32'h0};
    hi_we = 1'b1;
    hi_i  = 32'h22;
    lo_we = 1'b1;
    lo_i  = 32'h33;
    ex("hl_fwd_hi", K_HI, 32'h11);
    ex("hl_byp_lo", K_LO, 32'h33);
    fire();
    @(negedge clk);
    idle();
    ex("hl_reg_hi", K_HI, 32'h22);
    ex("hl_reg_lo", K_LO, 32'h33);
    fire();
`endif

    idle();
    bus.we    = 1'b1;
    bus.waddr = 5'd5;
    bus.wdata = 32'h1234;
    @(negedge clk);
    idle();
    bus.raddr = {5'd0, 5'd5};
    ex("r5_written", K_RD0, 32'h1234);
    fire();

    while (cyc < 99) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    bus.raddr = {5'd3, 5'd5};
    bus.we    = 1'b1;
    bus.waddr = 5'd5;
    bus.wdata = 32'hFFFF;
`ifdef RF_HILO_EN
    hi_we = 1'b1;
    hi_i  = 32'h77;
    ex("init_hi", K_HI, 32'd0);
    ex("init_lo", K_LO, 32'd0);
`endif
    ex("mid_busy", K_BSY, 32'd1);
    ex("mid_stall", K_STL, 32'd1);
    ex("mid_rd0", K_RD0, 32'd0);
    fire();
    count_init("mid_init_len");
    idle();
    bus.raddr = {5'd3, 5'd5};
    ex("mid_r5", K_RD0, 32'd0);
    ex("mid_r3", K_RD1, 32'd0);
    ex("mid_busy_done", K_BSY, 32'd0);
    fire();

    ex("queue_left", K_VAL, 32'd0, q.size());
    fire();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
